// File: rtl/arm_shift_pkg.sv
// Shared encodings for the ARM operand-2 shifter: shift types, decode forms, FSM states.
package arm_shift_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [1:0] FORM_IMM  = 2'd0;  // imm8 ROR 2*rot
    localparam logic [1:0] FORM_IMM5 = 2'd1;  // shift by 5-bit immediate
    localparam logic [1:0] FORM_REG  = 2'd2;  // shift by Rs[7:0]

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_RS = 2'd1,
        ST_OUT     = 2'd2
    } state_e;

endpackage

// File: rtl/shift_operand_ctrl_decode.sv
// Combinational operand-2 decode: turns form/type/amount into rotator amount, direction,
// keep-mask, fill bit and shifter carry-out. Latency 0; no flow control.
module shift_decode
    import arm_shift_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic [1:0]       form,
    input  logic [1:0]       sh_type,
    input  logic [AMT_W-1:0] amount,
    input  logic [31:0]      rm,
    input  logic             carry_in,
    output logic [4:0]       amt,
    output logic             dir,
    output logic [31:0]      mask,
    output logic             fill,
    output logic             carry
);

    logic [31:0] n_full;
    logic [31:0] n_eff;
    logic [4:0]  n5;
    logic [4:0]  rot2;
    logic        rrx;

    always_comb begin
        n_full = 32'(amount);
        n5     = amount[4:0];
        rot2   = {amount[3:0], 1'b0};
        n_eff  = n_full;
        rrx    = 1'b0;
        amt    = '0;
        dir    = 1'b0;
        mask   = '1;
        fill   = 1'b0;
        carry  = carry_in;

        if (form == FORM_IMM) begin
            amt = rot2;
            if (rot2 != 5'd0) begin
                carry = rm[rot2 - 5'd1];
            end
        end else begin
            // imm5 #0 encodes LSR/ASR #32 and RRX; fold those into the register-amount rules.
            if (form == FORM_IMM5 && n5 == 5'd0) begin
                n_eff = (sh_type == SH_LSR || sh_type == SH_ASR) ? 32'd32 : 32'd0;
                rrx   = (sh_type == SH_ROR);
            end
            dir = (sh_type == SH_LSL);

            if (rrx) begin
                amt   = 5'd1;
                mask  = 32'h7FFF_FFFF;
                fill  = carry_in;
                carry = rm[0];
            end else if (n_eff != 32'd0) begin
                case (sh_type)
                    SH_LSL: begin
                        if (n_eff < 32'd32) begin
                            amt   = n5;
                            mask  = 32'hFFFF_FFFF << n5;
                            carry = rm[5'd0 - n5];
                        end else begin
                            mask  = '0;
                            carry = (n_eff == 32'd32) ? rm[0] : 1'b0;
                        end
                    end
                    SH_LSR: begin
                        if (n_eff < 32'd32) begin
                            amt   = n5;
                            mask  = 32'hFFFF_FFFF >> n5;
                            carry = rm[n5 - 5'd1];
                        end else begin
                            mask  = '0;
                            carry = (n_eff == 32'd32) ? rm[31] : 1'b0;
                        end
                    end
                    SH_ASR: begin
                        fill = rm[31];
                        if (n_eff < 32'd32) begin
                            amt   = n5;
                            mask  = 32'hFFFF_FFFF >> n5;
                            carry = rm[n5 - 5'd1];
                        end else begin
                            mask  = '0;
                            carry = rm[31];
                        end
                    end
                    default: begin
                        // ROR by a non-zero multiple of 32 leaves the value but still yields rm[31].
                        if (n5 != 5'd0) begin
                            amt   = n5;
                            carry = rm[n5 - 5'd1];
                        end else begin
                            carry = rm[31];
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_operand_ctrl.sv
// Operand-2 control stage: accepts an op, optionally fetches Rs, presents registered rotator controls.
// Latency 1 cycle from accept (or from rs_valid); outputs held until out_ready, refill in the drain cycle.
module shift_operand_ctrl
    import arm_shift_pkg::*;
#(
    parameter int RS_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        imm_form,
    input  logic [11:0] op2,
    input  logic [31:0] rm_data,
    input  logic        carry_in,
    output logic        rs_req,
    input  logic        rs_valid,
    input  logic [31:0] rs_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sh_data,
    output logic [4:0]  sh_amt,
    output logic        sh_dir_lr,
    output logic [31:0] sh_mask,
    output logic        sh_fill,
    output logic        sh_carry
);

    localparam int AMT_W = (RS_BITS > 5) ? RS_BITS : 5;

    state_e      state_q;
    logic        alive_q;
    logic [1:0]  type_q;
    logic [31:0] rm_q;
    logic        cin_q;
    logic        out_valid_q;
    logic        rs_req_q;
    logic [31:0] sh_data_q;
    logic [4:0]  sh_amt_q;
    logic        sh_dir_q;
    logic [31:0] sh_mask_q;
    logic        sh_fill_q;
    logic        sh_carry_q;

    logic             wait_rs;
    logic             accept;
    logic             reg_shift;
    logic             load_out;
    logic [1:0]       dec_form_d;
    logic [1:0]       dec_type_d;
    logic [AMT_W-1:0] dec_amount_d;
    logic [31:0]      dec_rm_d;
    logic             dec_cin_d;
    logic [4:0]       dec_amt;
    logic             dec_dir;
    logic [31:0]      dec_mask;
    logic             dec_fill;
    logic             dec_carry;
    logic             unused_ok;

    // alive_q keeps in_ready low while reset is asserted and for the first edge after it.
    assign wait_rs   = (state_q == ST_WAIT_RS);
    assign in_ready  = alive_q & ((state_q == ST_IDLE) | ((state_q == ST_OUT) & out_ready));
    assign accept    = in_valid & in_ready;
    assign reg_shift = ~imm_form & op2[4];
    assign load_out  = (accept & ~reg_shift) | (wait_rs & rs_valid);
    assign unused_ok = ^{op2[3:0], rs_data};

    assign dec_form_d   = wait_rs ? FORM_REG : (imm_form ? FORM_IMM : FORM_IMM5);
    assign dec_type_d   = wait_rs ? type_q : op2[6:5];
    assign dec_amount_d = wait_rs  ? AMT_W'(rs_data[RS_BITS-1:0]) :
                          imm_form ? AMT_W'(op2[11:8]) : AMT_W'(op2[11:7]);
    assign dec_rm_d     = wait_rs  ? rm_q :
                          imm_form ? {24'b0, op2[7:0]} : rm_data;
    assign dec_cin_d    = wait_rs ? cin_q : carry_in;

    shift_decode #(.AMT_W(AMT_W)) u_decode (
        .form     (dec_form_d),
        .sh_type  (dec_type_d),
        .amount   (dec_amount_d),
        .rm       (dec_rm_d),
        .carry_in (dec_cin_d),
        .amt      (dec_amt),
        .dir      (dec_dir),
        .mask     (dec_mask),
        .fill     (dec_fill),
        .carry    (dec_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alive_q     <= 1'b0;
            type_q      <= '0;
            rm_q        <= '0;
            cin_q       <= 1'b0;
            out_valid_q <= 1'b0;
            rs_req_q    <= 1'b0;
            sh_data_q   <= '0;
            sh_amt_q    <= '0;
            sh_dir_q    <= 1'b0;
            sh_mask_q   <= '0;
            sh_fill_q   <= 1'b0;
            sh_carry_q  <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (flush) begin
                state_q     <= ST_IDLE;
                out_valid_q <= 1'b0;
                rs_req_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_OUT: begin
                        if (accept && reg_shift) begin
                            state_q     <= ST_WAIT_RS;
                            rs_req_q    <= 1'b1;
                            out_valid_q <= 1'b0;
                            type_q      <= op2[6:5];
                            rm_q        <= rm_data;
                            cin_q       <= carry_in;
                        end else if (accept) begin
                            state_q     <= ST_OUT;
                            out_valid_q <= 1'b1;
                        end else if (state_q == ST_IDLE || out_ready) begin
                            state_q     <= ST_IDLE;
                            out_valid_q <= 1'b0;
                        end
                    end
                    ST_WAIT_RS: begin
                        if (rs_valid) begin
                            state_q     <= ST_OUT;
                            rs_req_q    <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        rs_req_q    <= 1'b0;
                    end
                endcase
                if (load_out) begin
                    sh_data_q  <= dec_rm_d;
                    sh_amt_q   <= dec_amt;
                    sh_dir_q   <= dec_dir;
                    sh_mask_q  <= dec_mask;
                    sh_fill_q  <= dec_fill;
                    sh_carry_q <= dec_carry;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign rs_req    = rs_req_q;
    assign sh_data   = sh_data_q;
    assign sh_amt    = sh_amt_q;
    assign sh_dir_lr = sh_dir_q;
    assign sh_mask   = sh_mask_q;
    assign sh_fill   = sh_fill_q;
    assign sh_carry  = sh_carry_q;

endmodule

// File: tb/tb_shift_operand_ctrl.sv
// Bench for shift_operand_ctrl: directed cases plus randomized traffic against an arithmetic ARM shifter model.
module tb_shift_operand_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        imm_form = 1'b0;
    logic [11:0] op2 = '0;
    logic [31:0] rm_data = '0;
    logic        carry_in = 1'b0;
    logic        rs_req;
    logic        rs_valid = 1'b0;
    logic [31:0] rs_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sh_data;
    logic [4:0]  sh_amt;
    logic        sh_dir_lr;
    logic [31:0] sh_mask;
    logic        sh_fill;
    logic        sh_carry;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_operand_ctrl #(.RS_BITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_form  (imm_form),
        .op2       (op2),
        .rm_data   (rm_data),
        .carry_in  (carry_in),
        .rs_req    (rs_req),
        .rs_valid  (rs_valid),
        .rs_data   (rs_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sh_data   (sh_data),
        .sh_amt    (sh_amt),
        .sh_dir_lr (sh_dir_lr),
        .sh_mask   (sh_mask),
        .sh_fill   (sh_fill),
        .sh_carry  (sh_carry)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] v, input int n);
        int k;
        k = n % 32;
        return (v >> k) | (v << (32 - k));
    endfunction

    // What downstream builds from the presented controls.
    function automatic logic [31:0] dut_result();
        logic [31:0] r;
        int a;
        a = int'(sh_amt);
        r = sh_dir_lr ? ((sh_data << a) | (sh_data >> (32 - a))) : ror32(sh_data, a);
        return (r & sh_mask) | ({32{sh_fill}} & ~sh_mask);
    endfunction

    // ARM barrel-shifter semantics computed with wide arithmetic.
    task automatic ref_model(input logic imm, input logic [11:0] o, input logic [31:0] rm,
                             input logic c, input logic [31:0] rs,
                             output logic [31:0] res, output logic co);
        longint unsigned x;
        longint          xs;
        int              n;
        logic [1:0]      ty;
        logic [63:0]     w;
        ty = o[6:5];
        if (imm) begin
            n   = 2 * int'(o[11:8]);
            res = ror32({24'b0, o[7:0]}, n);
            co  = (n == 0) ? c : res[31];
            return;
        end
        n = o[4] ? int'(rs[7:0]) : int'(o[11:7]);
        if (!o[4] && n == 0 && ty == 2'b11) begin
            res = {c, rm[31:1]};
            co  = rm[0];
            return;
        end
        if (!o[4] && n == 0 && (ty == 2'b01 || ty == 2'b10)) n = 32;
        if (n == 0) begin
            res = rm;
            co  = c;
            return;
        end
        case (ty)
            2'b00: begin
                x   = {32'b0, rm};
                x   = x << n;
                w   = x;
                res = w[31:0];
                co  = w[32];
            end
            2'b01: begin
                x   = {rm, 32'b0};
                x   = x >> n;
                w   = x;
                res = w[63:32];
                co  = w[31];
            end
            2'b10: begin
                xs  = {rm, 32'b0};
                xs  = xs >>> ((n > 63) ? 63 : n);
                w   = xs;
                res = w[63:32];
                co  = w[31];
            end
            default: begin
                res = ror32(rm, n);
                co  = res[31];
            end
        endcase
    endtask

    task automatic issue(input logic imm, input logic [11:0] o, input logic [31:0] rm, input logic c);
        imm_form = imm;
        op2      = o;
        rm_data  = rm;
        carry_in = c;
        in_valid = 1'b1;
        #1;
        chk("issue_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("drain_out_valid", out_valid, 0);
    endtask

    localparam int NOPS = 300;

    logic [32:0] exp_q[$];
    logic [32:0] e;
    logic [31:0] m_res;
    logic        m_co;
    logic [31:0] op_rs;
    logic [31:0] pend_rs;
    logic        hold_v;
    logic [31:0] hold_dat;
    logic [31:0] hold_mask;
    logic [31:0] hold_res;
    int          issued;
    int          done;
    logic        acc;
    logic [31:0] d0;

    initial begin
        // reset state
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rs_req", rs_req, 0);
        chk("rst_sh_data", sh_data, 0);
        chk("rst_sh_mask", sh_mask, 0);
        chk("rst_misc", {sh_amt, sh_dir_lr, sh_fill, sh_carry}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        // imm8 ROR 2*rot
        issue(1'b1, 12'h4FF, 32'h0, 1'b0);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", sh_data, 32'hFF);
        chk("t1_amt", sh_amt, 8);
        chk("t1_dir", sh_dir_lr, 0);
        chk("t1_mask", sh_mask, 32'hFFFF_FFFF);
        chk("t1_carry", sh_carry, 1);
        drain();

        // imm5 LSR #0 is LSR 32
        issue(1'b0, 12'h020, 32'h8000_0001, 1'b0);
        chk("t2_mask", sh_mask, 0);
        chk("t2_fill", sh_fill, 0);
        chk("t2_carry", sh_carry, 1);
        chk("t2_amt", sh_amt, 0);
        chk("t2_result", dut_result(), 0);
        drain();

        // register ASR by 64
        issue(1'b0, 12'h050, 32'h8000_0000, 1'b0);
        chk("t3_rs_req", rs_req, 1);
        chk("t3_wait_valid", out_valid, 0);
        rs_valid = 1'b1;
        rs_data  = 32'h40;
        @(negedge clk);
        rs_valid = 1'b0;
        chk("t3_valid", out_valid, 1);
        chk("t3_rs_req_off", rs_req, 0);
        chk("t3_mask", sh_mask, 0);
        chk("t3_fill", sh_fill, 1);
        chk("t3_carry", sh_carry, 1);
        drain();

        // RRX
        issue(1'b0, 12'h060, 32'h3, 1'b1);
        chk("t4_amt", sh_amt, 1);
        chk("t4_dir", sh_dir_lr, 0);
        chk("t4_mask", sh_mask, 32'h7FFF_FFFF);
        chk("t4_fill", sh_fill, 1);
        chk("t4_carry", sh_carry, 1);
        chk("t4_result", dut_result(), 32'h8000_0001);
        drain();

        // backpressure then back-to-back refill
        issue(1'b1, 12'h1AB, 32'h0, 1'b0);
        d0 = sh_data;
        for (int i = 0; i < 3; i++) begin
            chk("t5_stable", sh_data, 32'hAB);
            chk("t5_held_valid", out_valid, 1);
            chk("t5_in_ready", in_ready, 0);
            @(negedge clk);
        end
        chk("t5_stable_last", sh_data, d0);
        out_ready = 1'b1;
        imm_form  = 1'b1;
        op2       = 12'h05A;
        in_valid  = 1'b1;
        #1;
        chk("t5_drain_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t5_no_bubble", out_valid, 1);
        chk("t5_new_data", sh_data, 32'h5A);
        drain();

        // async reset while waiting for Rs
        issue(1'b0, 12'h050, 32'h1234_5678, 1'b1);
        chk("t6_rs_req", rs_req, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rs_req", rs_req, 0);
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        chk("t6_rst_mask", sh_mask, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // flush beats a same-cycle rs_valid
        issue(1'b0, 12'h050, 32'h8000_0000, 1'b0);
        chk("t7_rs_req", rs_req, 1);
        flush    = 1'b1;
        rs_valid = 1'b1;
        rs_data  = 32'h40;
        @(negedge clk);
        flush    = 1'b0;
        rs_valid = 1'b0;
        chk("t7_out_valid", out_valid, 0);
        chk("t7_rs_req_off", rs_req, 0);
        chk("t7_in_ready", in_ready, 1);
        @(negedge clk);
        chk("t7_out_valid_later", out_valid, 0);

        // randomized traffic
        issued  = 0;
        done    = 0;
        hold_v  = 1'b0;
        pend_rs = '0;
        op_rs   = '0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (!in_valid && issued < NOPS && $urandom_range(3) != 0) begin
                imm_form = 1'($urandom_range(1));
                op2      = 12'($urandom);
                if ($urandom_range(3) == 0) op2[11:7] = 5'd0;
                case ($urandom_range(3))
                    0: rm_data = 32'h8000_0000 | 32'($urandom_range(1));
                    1: rm_data = 32'hFFFF_FFFF;
                    default: rm_data = $urandom;
                endcase
                carry_in = 1'($urandom_range(1));
                op_rs    = $urandom;
                case ($urandom_range(5))
                    0: op_rs[7:0] = 8'd0;
                    1: op_rs[7:0] = 8'd32;
                    2: op_rs[7:0] = 8'($urandom_range(31));
                    3: op_rs[7:0] = 8'($urandom_range(255, 33));
                    4: op_rs[7:0] = 8'(32 * $urandom_range(7));
                    default: ;
                endcase
                in_valid = 1'b1;
            end
            out_ready = (issued >= NOPS) ? 1'b1 : 1'($urandom_range(2) != 0);
            if (rs_req && $urandom_range(1) == 1) begin
                rs_valid = 1'b1;
                rs_data  = pend_rs;
            end else begin
                rs_valid = 1'b0;
                rs_data  = $urandom;
            end
            #1;
            if (hold_v) begin
                chk("rnd_hold_valid", out_valid, 1);
                chk("rnd_hold_data", sh_data, hold_dat);
                chk("rnd_hold_mask", sh_mask, hold_mask);
                chk("rnd_hold_result", dut_result(), hold_res);
            end
            hold_v = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious", out_valid, 0);
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    chk("rnd_result", dut_result(), e[31:0]);
                    chk("rnd_carry", sh_carry, e[32]);
                    if (sh_mask == 32'h0) chk("rnd_amt_when_mask0", sh_amt, 0);
                    done++;
                end else begin
                    hold_v    = 1'b1;
                    hold_dat  = sh_data;
                    hold_mask = sh_mask;
                    hold_res  = dut_result();
                end
            end
            acc = in_valid & in_ready;
            if (acc) begin
                ref_model(imm_form, op2, rm_data, carry_in, op_rs, m_res, m_co);
                exp_q.push_back({m_co, m_res});
                if (!imm_form && op2[4]) pend_rs = op_rs;
                issued++;
            end
            @(negedge clk);
            if (acc) in_valid = 1'b0;
            if (issued >= NOPS && exp_q.size() == 0 && !out_valid && !rs_req && !in_valid) break;
        end
        chk("rnd_all_done", done, NOPS);
        chk("rnd_queue_empty", exp_q.size(), 0);
        chk("end_in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
